// File: rtl/bitwave_pkg.sv
// Shared types and width helpers for the BitWave bit-column MAC.
package bitwave_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Width of one column's lane sum: sign-extended act plus tree growth.
    function automatic int unsigned tree_width(input int unsigned data_width,
                                               input int unsigned vec_length);
        return data_width + 1 + $clog2(vec_length);
    endfunction

    function automatic int unsigned acc_width(input int unsigned data_width,
                                              input int unsigned vec_length,
                                              input int unsigned mag_cols,
                                              input int unsigned acc_guard);
        return tree_width(data_width, vec_length) + mag_cols + acc_guard;
    endfunction

endpackage

// File: rtl/bitwave_col_tree.sv
// One weight bit-column: per-lane conditional negate/select, then a binary adder tree.
module bitwave_col_tree
    import bitwave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned VEC_LENGTH = 16
) (
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0]                   act,
    input  logic [VEC_LENGTH-1:0]                              w_sign,
    input  logic [VEC_LENGTH-1:0]                              col_bits,
    output logic signed [tree_width(DATA_WIDTH, VEC_LENGTH)-1:0] col_sum
);

    localparam int unsigned TW     = tree_width(DATA_WIDTH, VEC_LENGTH);
    localparam int unsigned LEVELS = $clog2(VEC_LENGTH);

    for (genvar lv = 0; lv <= LEVELS; lv++) begin : g_lvl
        logic signed [TW-1:0] n [VEC_LENGTH >> lv];

        if (lv == 0) begin : g_leaf
            // One extra bit so the most negative activation negates exactly.
            for (genvar i = 0; i < VEC_LENGTH; i++) begin : g_lane
                logic signed [DATA_WIDTH:0] a_ext;
                logic signed [DATA_WIDTH:0] term;
                assign a_ext = {act[i*DATA_WIDTH+DATA_WIDTH-1], act[i*DATA_WIDTH +: DATA_WIDTH]};
                assign term  = col_bits[i] ? (w_sign[i] ? -a_ext : a_ext) : '0;
                assign n[i]  = TW'(term);
            end
        end else begin : g_sum
            for (genvar j = 0; j < (VEC_LENGTH >> lv); j++) begin : g_node
                assign n[j] = g_lvl[lv-1].n[2*j] + g_lvl[lv-1].n[2*j+1];
            end
        end
    end

    assign col_sum = g_lvl[LEVELS].n[0];

endmodule

// File: rtl/bitwave_mac_seq.sv
// Self-sequencing bit-column MAC: walks the set columns of a mask one per cycle,
// accumulates across vectors and emits a shifted, saturated result.
module bitwave_mac_seq
    import bitwave_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned VEC_LENGTH   = 16,
    parameter int unsigned W_PREC       = 8,
    parameter int unsigned ACC_GUARD    = 8,
    parameter int unsigned ACC_WIDTH    = acc_width(DATA_WIDTH, VEC_LENGTH, W_PREC - 1, ACC_GUARD),
    parameter int unsigned OUT_SHIFT    = 8,
    parameter int unsigned RESULT_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [VEC_LENGTH*DATA_WIDTH-1:0]   act,
    input  logic [VEC_LENGTH-1:0]              w_sign,
    input  logic [VEC_LENGTH*(W_PREC-1)-1:0]   w_mag,
    input  logic [W_PREC-2:0]                  col_mask,
    input  logic                               in_first,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [RESULT_WIDTH-1:0]     result,
    output logic                               sat
);

    localparam int unsigned M  = W_PREC - 1;
    localparam int unsigned TW = tree_width(DATA_WIDTH, VEC_LENGTH);
    localparam int unsigned MW = (M > 1) ? $clog2(M) : 1;
    localparam int unsigned PW = TW + M;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        ACC_WIDTH'((64'sd1 <<< (RESULT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    state_t state, state_next;

    logic [VEC_LENGTH*DATA_WIDTH-1:0] act_reg;
    logic [VEC_LENGTH-1:0]            sign_reg;
    logic [M-1:0]                     w_mag_lane [VEC_LENGTH];
    logic [M-1:0]                     mag_lane   [VEC_LENGTH];
    logic [M-1:0]                     rem_mask, rem_mask_next;
    logic                             last_reg;
    logic signed [PW-1:0]             psum_reg, col_shifted;
    logic                             psum_pend;
    logic signed [ACC_WIDTH-1:0]      acc, acc_next, acc_shifted;
    logic [MW-1:0]                    col_idx;
    logic [VEC_LENGTH-1:0]            col_bits;
    logic signed [TW-1:0]             col_sum;
    logic                             accept;
    logic                             in_ready_d, out_valid_d, load_result;
    logic signed [RESULT_WIDTH-1:0]   result_d;
    logic                             sat_d;

    assign accept = in_valid && (state == IDLE);

    for (genvar i = 0; i < VEC_LENGTH; i++) begin : g_unpack
        assign w_mag_lane[i] = w_mag[i*M +: M];
        assign col_bits[i]   = mag_lane[i][col_idx];
    end

    // Lowest remaining column is issued first.
    always_comb begin
        col_idx = '0;
        for (int k = M - 1; k >= 0; k--) begin
            if (rem_mask[k]) col_idx = MW'(k);
        end
        rem_mask_next = rem_mask & (rem_mask - M'(1));
    end

    bitwave_col_tree #(
        .DATA_WIDTH (DATA_WIDTH),
        .VEC_LENGTH (VEC_LENGTH)
    ) u_col_tree (
        .act      (act_reg),
        .w_sign   (sign_reg),
        .col_bits (col_bits),
        .col_sum  (col_sum)
    );

    assign col_shifted = PW'(col_sum) <<< col_idx;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (col_mask != '0) state_next = RUN;
                    else if (in_last)   state_next = OUT;
                end
            end
            RUN:     if (rem_mask_next == '0) state_next = DRAIN;
            DRAIN:   state_next = last_reg ? OUT : IDLE;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state; result loads on entry to OUT.
    always_comb begin
        in_ready_d  = (state_next == IDLE);
        out_valid_d = (state_next == OUT);
        load_result = (state_next == OUT) && (state != OUT);
    end

    always_comb begin
        acc_next = acc;
        if (accept && in_first) acc_next = '0;
        if (psum_pend)          acc_next = acc + ACC_WIDTH'(psum_reg);
        acc_shifted = acc_next >>> OUT_SHIFT;
        if (acc_shifted > SAT_MAX) begin
            result_d = RESULT_WIDTH'(SAT_MAX);
            sat_d    = 1'b1;
        end else if (acc_shifted < SAT_MIN) begin
            result_d = RESULT_WIDTH'(SAT_MIN);
            sat_d    = 1'b1;
        end else begin
            result_d = RESULT_WIDTH'(acc_shifted);
            sat_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            sat       <= 1'b0;
            acc       <= '0;
            psum_reg  <= '0;
            psum_pend <= 1'b0;
            rem_mask  <= '0;
            last_reg  <= 1'b0;
            act_reg   <= '0;
            sign_reg  <= '0;
            for (int i = 0; i < VEC_LENGTH; i++) mag_lane[i] <= '0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            acc       <= acc_next;
            psum_pend <= (state == RUN);
            if (state == RUN) begin
                psum_reg <= col_shifted;
                rem_mask <= rem_mask_next;
            end
            if (accept) begin
                act_reg  <= act;
                sign_reg <= w_sign;
                mag_lane <= w_mag_lane;
                rem_mask <= col_mask;
                last_reg <= in_last;
            end
            if (load_result) begin
                result <= result_d;
                sat    <= sat_d;
            end
        end
    end

endmodule

// File: tb/tb_bitwave_mac_seq.sv
// Directed bench for bitwave_mac_seq with an arithmetic reference model and per-cycle compare.
module tb_bitwave_mac_seq;

    localparam int DW  = 8;
    localparam int VL  = 16;
    localparam int M   = 7;
    localparam int AW  = 28;
    localparam int OSH = 0;
    localparam int RW  = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [VL*DW-1:0]      act = '0;
    logic [VL-1:0]         w_sign = '0;
    logic [VL*M-1:0]       w_mag = '0;
    logic [M-1:0]          col_mask = '0;
    logic                  in_first = 1'b0;
    logic                  in_last = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic signed [RW-1:0]  result;
    logic                  sat;

    bitwave_mac_seq #(.OUT_SHIFT(OSH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act       (act),
        .w_sign    (w_sign),
        .w_mag     (w_mag),
        .col_mask  (col_mask),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: whole-vector dot products, modular accumulator, clip.
    function automatic longint vec_sum(input logic [VL*DW-1:0] a, input logic [VL-1:0] s,
                                       input logic [VL*M-1:0] mg, input logic [M-1:0] cm);
        longint tot;
        longint t;
        logic signed [DW-1:0] x;
        tot = 0;
        for (int l = 0; l < VL; l++) begin
            for (int m = 0; m < M; m++) begin
                if (cm[m] && mg[l*M+m]) begin
                    x = a[l*DW +: DW];
                    t = x;
                    if (s[l]) t = -t;
                    tot += t * (longint'(1) << m);
                end
            end
        end
        return tot;
    endfunction

    function automatic longint wrap_acc(input longint v);
        logic signed [AW-1:0] t;
        longint r;
        t = AW'(v);
        r = t;
        return r;
    endfunction

    logic   m_ready = 1'b1;
    logic   m_valid = 1'b0;
    logic   m_sat   = 1'b0;
    logic   m_last  = 1'b0;
    longint m_acc   = 0;
    longint m_res   = 0;
    int     m_cnt   = 0;
    bit     started = 1'b0;

    task automatic m_emit();
        longint s;
        s = m_acc >>> OSH;
        if (s > 32767)       begin m_res = 32767;  m_sat = 1'b1; end
        else if (s < -32768) begin m_res = -32768; m_sat = 1'b1; end
        else                 begin m_res = s;      m_sat = 1'b0; end
        m_valid = 1'b1;
        m_ready = 1'b0;
    endtask

    always @(posedge clk) begin
        int k;
        if (reset) begin
            m_ready = 1'b1; m_valid = 1'b0; m_res = 0; m_sat = 1'b0; m_acc = 0; m_cnt = 0;
        end else if (m_valid) begin
            if (out_ready) begin m_valid = 1'b0; m_ready = 1'b1; end
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                if (m_last) m_emit();
                else        m_ready = 1'b1;
            end
        end else if (m_ready && in_valid) begin
            m_acc  = wrap_acc((in_first ? 64'sd0 : m_acc) + vec_sum(act, w_sign, w_mag, col_mask));
            m_last = in_last;
            k = $countones(col_mask);
            if (k == 0) begin
                if (in_last) m_emit();
            end else begin
                m_ready = 1'b0;
                m_cnt   = k + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", in_ready, m_ready);
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("result", result, m_res);
                chk("sat", sat, m_sat);
            end
        end
    end

    function automatic logic [VL*DW-1:0] rep_act(input logic [DW-1:0] v);
        logic [VL*DW-1:0] r;
        for (int i = 0; i < VL; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [VL*M-1:0] rep_mag(input logic [M-1:0] v);
        logic [VL*M-1:0] r;
        for (int i = 0; i < VL; i++) r[i*M +: M] = v;
        return r;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) chk("ready_timeout", in_ready, 1);
    endtask

    // Presents one vector; returns at the negedge of the first cycle after the accept edge.
    task automatic send(input logic [VL*DW-1:0] a, input logic [VL-1:0] s,
                        input logic [VL*M-1:0] mg, input logic [M-1:0] cm,
                        input logic first, input logic last);
        wait_ready();
        act = a; w_sign = s; w_mag = mg; col_mask = cm; in_first = first; in_last = last;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (out_valid !== 1'b1) chk("out_timeout", out_valid, 1);
    endtask

    initial begin
        int cyc;
        logic [VL*DW-1:0] a;
        logic [VL*M-1:0]  mg;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_sat", sat, 0);
        reset = 1'b0;
        started = 1'b1;

        // Two columns of act=3 x mag=5.
        send(rep_act(8'd3), '0, rep_mag(7'd5), 7'b0000101, 1'b1, 1'b1);
        wait_out(cyc);
        chk("t1_latency", cyc, 4);
        chk("t1_result", result, 240);
        chk("t1_sat", sat, 0);

        // Most negative activation times -1.
        a = rep_act(8'd5);
        a[DW-1:0] = 8'h80;
        mg = '0;
        mg[0] = 1'b1;
        send(a, 16'h0001, mg, 7'b0000001, 1'b1, 1'b1);
        wait_out(cyc);
        chk("t2_latency", cyc, 3);
        chk("t2_result", result, 128);

        // Empty mask with last: immediate output of zero.
        send(rep_act(8'd7), '0, rep_mag(7'h7F), 7'b0, 1'b1, 1'b1);
        wait_out(cyc);
        chk("t3_latency", cyc, 1);
        chk("t3_result", result, 0);

        // Accumulate across vectors with an empty-mask vector in between.
        send(rep_act(8'd1), '0, rep_mag(7'd1), 7'b0000001, 1'b1, 1'b0);
        send(rep_act(8'd9), '0, rep_mag(7'h55), 7'b0, 1'b0, 1'b0);
        chk("t4_empty_ready", in_ready, 1);
        chk("t4_empty_valid", out_valid, 0);
        send(rep_act(8'd1), '0, rep_mag(7'd1), 7'b0000001, 1'b0, 1'b1);
        wait_out(cyc);
        chk("t4_result", result, 32);

        // Backpressure: result held, no accept while output pending.
        send(rep_act(8'd1), '0, rep_mag(7'd1), 7'b0000001, 1'b1, 1'b0);
        out_ready = 1'b0;
        send(rep_act(8'd1), '0, rep_mag(7'd1), 7'b0000001, 1'b0, 1'b1);
        wait_out(cyc);
        chk("t5_result", result, 32);
        act = rep_act(8'd50); col_mask = 7'd1; in_first = 1'b1; in_last = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_hold_result", result, 32);
            chk("t5_hold_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_release_ready", in_ready, 1);

        // Positive and negative saturation.
        send(rep_act(8'd127), '0, rep_mag(7'h7F), 7'h7F, 1'b1, 1'b1);
        wait_out(cyc);
        chk("t6_latency", cyc, 9);
        chk("t6_result", result, 32767);
        chk("t6_sat", sat, 1);
        send(rep_act(8'd127), 16'hFFFF, rep_mag(7'h7F), 7'h7F, 1'b1, 1'b1);
        wait_out(cyc);
        chk("t7_result", result, -32768);
        chk("t7_sat", sat, 1);

        // Reset during the second RUN cycle clears everything.
        send(rep_act(8'd127), '0, rep_mag(7'h7F), 7'h7F, 1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t8_rst_ready", in_ready, 1);
        chk("t8_rst_valid", out_valid, 0);
        send(rep_act(8'd1), '0, rep_mag(7'd1), 7'b0000001, 1'b0, 1'b1);
        wait_out(cyc);
        chk("t8_result", result, 16);
        chk("t8_sat", sat, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
